// File: rtl/kirsch_pkg.sv
// Shared types and constants for the Kirsch compass scheduler.
// Ring geometry and kernel weights live here; no kernel tables.
package kirsch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    // Border positions clockwise from the top-left corner.
    localparam int RING_R [8] = '{0, 0, 0, 1, 2, 2, 2, 1};
    localparam int RING_C [8] = '{0, 1, 2, 2, 2, 1, 0, 0};

    localparam int W_HI = 5;
    localparam int W_LO = -3;

    localparam int ACC_W_DFLT = 16;

endpackage

// File: rtl/kirsch_mac3x3.sv
// Shared 3x3 multiply-accumulate for one compass direction.
// Weights come from the ring offset relative to dir.
import kirsch_pkg::*;

module kirsch_mac3x3 #(
    parameter int PIX_W = 8,
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic [9*PIX_W-1:0]      pix,
    input  logic [2:0]              dir,
    output logic signed [ACC_W-1:0] sum
);

    logic [2:0]              rel;
    logic signed [PIX_W-1:0] pix_s;
    logic signed [ACC_W-1:0] pix_e;
    logic signed [ACC_W-1:0] wt;

    // Sum the eight ring pixels; +5 on the three cells at dir..dir+2.
    always_comb begin
        sum   = '0;
        rel   = '0;
        pix_s = '0;
        pix_e = '0;
        wt    = '0;
        for (int i = 0; i < 8; i++) begin
            rel   = 3'(i) - dir;
            pix_s = pix[(RING_R[i]*3 + RING_C[i])*PIX_W +: PIX_W];
            pix_e = ACC_W'(pix_s);
            wt    = (rel < 3'd3) ? ACC_W'(W_HI) : ACC_W'(W_LO);
            sum   = sum + pix_e * wt;
        end
    end

endmodule

// File: rtl/kirsch_compass_sched.sv
// Evaluates all eight Kirsch kernels on one window, one per clock,
// through a single shared MAC; emits clamped best magnitude and dir.
import kirsch_pkg::*;

module kirsch_compass_sched #(
    parameter int PIX_W = 8,
    parameter int ACC_W = ACC_W_DFLT,
    parameter int CLAMP = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [9*PIX_W-1:0]      win_pix,
    input  logic                    win_border,
    input  logic [7:0]              dir_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_mag,
    output logic [2:0]              out_dir,
    output logic signed [ACC_W-1:0] out_raw,
    output logic                    busy
);

    state_t state_q, state_d;

    logic [9*PIX_W-1:0]      win_q;
    logic [7:0]              mask_q;
    logic [2:0]              d_q;
    logic [ACC_W-1:0]        best_abs_q;
    logic [2:0]              best_dir_q;
    logic signed [ACC_W-1:0] best_raw_q;
    logic [7:0]              mag_q;
    logic [2:0]              dir_q;
    logic signed [ACC_W-1:0] raw_q;

    logic signed [ACC_W-1:0] sum;
    logic [ACC_W-1:0]        sum_abs;
    logic                    upd;
    logic [ACC_W-1:0]        nb_abs;
    logic [2:0]              nb_dir;
    logic signed [ACC_W-1:0] nb_raw;
    logic [7:0]              nb_mag;
    logic                    accept;

    kirsch_mac3x3 #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .pix (win_q),
        .dir (d_q),
        .sum (sum)
    );

    // Candidate best after considering the current direction.
    always_comb begin
        sum_abs = sum[ACC_W-1] ? -sum : sum;
        upd     = mask_q[d_q] && (sum_abs > best_abs_q);
        nb_abs  = upd ? sum_abs : best_abs_q;
        nb_dir  = upd ? d_q : best_dir_q;
        nb_raw  = upd ? sum : best_raw_q;
        nb_mag  = (nb_abs > ACC_W'(CLAMP)) ? 8'(CLAMP)
                                           : nb_abs[7:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        win_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                win_ready = !rst;
                if (win_valid) begin
                    accept  = 1'b1;
                    state_d = win_border ? OUT : EVAL;
                end
            end
            EVAL: begin
                busy = 1'b1;
                if (d_q == DIR_NW) state_d = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window latch, direction counter, best tracking and result regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            mask_q     <= '0;
            d_q        <= '0;
            best_abs_q <= '0;
            best_dir_q <= '0;
            best_raw_q <= '0;
            mag_q      <= '0;
            dir_q      <= '0;
            raw_q      <= '0;
        end else if (accept) begin
            win_q      <= win_pix;
            mask_q     <= dir_mask;
            d_q        <= '0;
            best_abs_q <= '0;
            best_dir_q <= '0;
            best_raw_q <= '0;
            mag_q      <= '0;
            dir_q      <= '0;
            raw_q      <= '0;
        end else if (state_q == EVAL) begin
            d_q        <= d_q + 3'd1;
            best_abs_q <= nb_abs;
            best_dir_q <= nb_dir;
            best_raw_q <= nb_raw;
            if (d_q == DIR_NW) begin
                mag_q <= nb_mag;
                dir_q <= nb_dir;
                raw_q <= nb_raw;
            end
        end
    end

    assign out_mag = mag_q;
    assign out_dir = dir_q;
    assign out_raw = raw_q;

endmodule
